// File: rtl/instr_mem_fetch_if.sv
// Fetch handshake and program-port bundle between the fetch stage and the instruction store.
interface instr_mem_fetch_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_addr;
  logic              addr_fault;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_err;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    output fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
    input  instruction, instr_valid, instr_addr, addr_fault, prog_err, fetch_count
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
    output instruction, instr_valid, instr_addr, addr_fault, prog_err, fetch_count
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Synchronous-read instruction store with a programming port, a fetch handshake
// (stall/flush) and out-of-range fetches that return the NOP encoding.
module instr_mem_fetch #(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DEPTH    = 32,
  parameter logic [DATA_W-1:0]    NOP_WORD = 16'hFFFF,
  parameter int unsigned          CNT_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  instr_mem_fetch_if.slave   bus
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DepthCmp = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fault_q, fault_d;
  logic              prog_err_q, prog_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic            fetch_in_range, prog_in_range, accept, bypass;
  logic [IdxW-1:0] fetch_idx, prog_idx;

  always_comb begin
    fetch_in_range = {1'b0, bus.fetch_addr} < DepthCmp;
    prog_in_range  = {1'b0, bus.prog_addr} < DepthCmp;
    fetch_idx      = bus.fetch_addr[IdxW-1:0];
    prog_idx       = bus.prog_addr[IdxW-1:0];
    accept         = bus.fetch_req && !bus.stall && !bus.flush;
    bypass         = bus.prog_we && (bus.prog_addr == bus.fetch_addr);
  end

  // Memory is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && prog_in_range) begin
      mem_q[prog_idx] <= bus.prog_data;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    prog_err_d = bus.prog_we && !prog_in_range;
    if (bus.flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (bus.stall) begin
      // hold everything
    end else if (accept) begin
      valid_d = 1'b1;
      addr_d  = bus.fetch_addr;
      cnt_d   = cnt_q + 1'b1;
      if (fetch_in_range) begin
        instr_d = bypass ? bus.prog_data : mem_q[fetch_idx];
        fault_d = 1'b0;
      end else begin
        instr_d = NOP_WORD;
        fault_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      fault_q    <= 1'b0;
      prog_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      prog_err_q <= prog_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_addr  = addr_q;
  assign bus.addr_fault  = fault_q;
  assign bus.prog_err    = prog_err_q;
  assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: program, fetch, range faults, stall/flush,
// bypass, async reset and fetch counter wrap.
module tb_instr_mem_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instr_mem_fetch_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(16)) bus ();

  instr_mem_fetch #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (32),
    .NOP_WORD(16'hFFFF),
    .CNT_W   (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ins, input logic vld,
                         input logic [15:0] adr, input logic flt, input logic [15:0] cnt);
    chk({tag, ".instruction"}, 32'(bus.instruction), 32'(ins));
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(vld));
    chk({tag, ".instr_addr"},  32'(bus.instr_addr),  32'(adr));
    chk({tag, ".addr_fault"},  32'(bus.addr_fault),  32'(flt));
    chk({tag, ".fetch_count"}, 32'(bus.fetch_count), 32'(cnt));
  endtask

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;

    // Reset held for two cycles, then idle
    tick();
    tick();
    chk_out("reset", 16'hFFFF, 1'b0, 16'd0, 1'b0, 16'd0);
    chk("reset.prog_err", 32'(bus.prog_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("idle", 16'hFFFF, 1'b0, 16'd0, 1'b0, 16'd0);

    // Program addresses 1 and 2
    bus.prog_we = 1'b1; bus.prog_addr = 16'd1; bus.prog_data = 16'h3301;
    tick();
    bus.prog_addr = 16'd2; bus.prog_data = 16'h3412;
    tick();
    bus.prog_we = 1'b0;
    chk("prog_ok.prog_err", 32'(bus.prog_err), 32'd0);

    // Back-to-back fetches
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd1;
    tick();
    chk_out("fetch1", 16'h3301, 1'b1, 16'd1, 1'b0, 16'd1);
    bus.fetch_addr = 16'd2;
    tick();
    chk_out("fetch2", 16'h3412, 1'b1, 16'd2, 1'b0, 16'd2);
    bus.fetch_req = 1'b0;
    tick();
    chk_out("idle_hold", 16'h3412, 1'b0, 16'd2, 1'b0, 16'd2);

    // Out-of-range fetch
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd40;
    tick();
    chk_out("oor_fetch", 16'hFFFF, 1'b1, 16'd40, 1'b1, 16'd3);
    bus.fetch_req = 1'b0;

    // Out-of-range program write: one-cycle error, no aliasing into address 0
    bus.prog_we = 1'b1; bus.prog_addr = 16'd32; bus.prog_data = 16'h1234;
    tick();
    bus.prog_we = 1'b0;
    chk("oor_prog.prog_err", 32'(bus.prog_err), 32'd1);
    tick();
    chk("oor_prog.pulse_end", 32'(bus.prog_err), 32'd0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd0;
    tick();
    chk_out("mem0_untouched", 16'hFFFF, 1'b1, 16'd0, 1'b0, 16'd4);

    // Stall holds outputs and ignores fetch_req
    bus.fetch_addr = 16'd1;
    tick();
    chk_out("pre_stall", 16'h3301, 1'b1, 16'd1, 1'b0, 16'd5);
    bus.stall = 1'b1; bus.fetch_addr = 16'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stall%0d", i), 16'h3301, 1'b1, 16'd1, 1'b0, 16'd5);
    end

    // Flush beats stall and fetch_req
    bus.flush = 1'b1;
    tick();
    chk_out("flush", 16'hFFFF, 1'b0, 16'd1, 1'b0, 16'd5);
    bus.flush = 1'b0; bus.stall = 1'b0; bus.fetch_req = 1'b0;

    // Write-first bypass on same-cycle write and fetch
    bus.prog_we = 1'b1; bus.prog_addr = 16'd3; bus.prog_data = 16'h1528;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd3;
    tick();
    bus.prog_we = 1'b0;
    chk_out("bypass", 16'h1528, 1'b1, 16'd3, 1'b0, 16'd6);

    // Range boundary: last legal word and first illegal one
    bus.fetch_addr = 16'd31;
    tick();
    chk_out("addr31", 16'hFFFF, 1'b1, 16'd31, 1'b0, 16'd7);
    bus.fetch_addr = 16'd32;
    tick();
    chk_out("addr32", 16'hFFFF, 1'b1, 16'd32, 1'b1, 16'd8);

    // Async reset between edges during back-to-back fetches
    bus.fetch_addr = 16'd1;
    tick();
    chk_out("pre_rst", 16'h3301, 1'b1, 16'd1, 1'b0, 16'd9);
    bus.fetch_addr = 16'd2;
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 16'hFFFF, 1'b0, 16'd0, 1'b0, 16'd0);
    bus.fetch_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk_out("post_rst_idle", 16'hFFFF, 1'b0, 16'd0, 1'b0, 16'd0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'd1;
    tick();
    chk_out("mem1_survives", 16'h3301, 1'b1, 16'd1, 1'b0, 16'd1);

    // Fetch counter wrap
    repeat (65534) @(posedge clk);
    #1;
    chk("cnt_allones", 32'(bus.fetch_count), 32'h0000FFFF);
    tick();
    chk("cnt_wrap", 32'(bus.fetch_count), 32'h00000000);
    bus.fetch_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
